// File: rtl/trim_avg_filter.sv
// trim_avg_filter: window of 2^AVG_SHIFT+2 samples, drop one min and one max, emit rounded mean
module trim_avg_filter #(
    parameter int AVG_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        filter_valid,
    output logic [15:0] filter_data,
    output logic        window_busy
);
    localparam int N  = (1 << AVG_SHIFT) + 2;
    localparam int SW = 16 + AVG_SHIFT + 2;
    localparam int CW = $clog2(N);
    localparam logic [1:0] S_ACC  = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sum;
    logic [SW-1:0] trimmed;
    logic [15:0]   mn;
    logic [15:0]   mx;
    logic [15:0]   result;

    // trimmed sum with half-LSB bias so the shift rounds half up
    always_comb begin
        trimmed = sum - SW'(mn) - SW'(mx) + (SW'(1) << (AVG_SHIFT - 1));
    end

    // collect window, compute mean, then pulse the result for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_ACC;
            cnt          <= '0;
            sum          <= '0;
            mn           <= 16'hFFFF;
            mx           <= 16'h0000;
            result       <= 16'h0000;
            filter_valid <= 1'b0;
            filter_data  <= 16'h0000;
            window_busy  <= 1'b0;
        end else begin
            filter_valid <= 1'b0;
            case (state)
                S_ACC: if (sample_valid) begin
                    sum         <= sum + SW'(sample_data);
                    mn          <= (cnt == '0 || sample_data < mn) ? sample_data : mn;
                    mx          <= (cnt == '0 || sample_data > mx) ? sample_data : mx;
                    window_busy <= 1'b1;
                    state       <= (cnt == CW'(N - 1)) ? S_CALC : S_ACC;
                    cnt         <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
                end
                S_CALC: begin
                    result <= 16'(trimmed >> AVG_SHIFT);
                    state  <= S_OUT;
                end
                S_OUT: begin
                    filter_valid <= 1'b1;
                    filter_data  <= result;
                    sum          <= '0;
                    mn           <= 16'hFFFF;
                    mx           <= 16'h0000;
                    window_busy  <= 1'b0;
                    state        <= S_ACC;
                end
                default: state <= S_ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_trim_avg_filter.sv
// tb_trim_avg_filter: directed windows with a queue-based scoreboard checking data and pulse timing
module tb_trim_avg_filter;
    typedef logic [15:0] win_t [6];
    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = 16'h0000;
    logic        filter_valid;
    logic [15:0] filter_data;
    logic        window_busy;

    int   compared = 0;
    int   mism = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    trim_avg_filter #(.AVG_SHIFT(2)) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .filter_valid(filter_valid),
        .filter_data(filter_data),
        .window_busy(window_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mism++;
            $display("FAIL %s got %0d expected %0d", n, a, e);
        end
    endtask

    // monitor: every pulse must match the oldest expected result, both value and cycle
    always @(negedge clk) begin
        if (filter_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mism++;
                $display("FAIL unexpected_pulse got data %0d at cycle %0d expected no pulse", filter_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_data", 32'(filter_data), 32'(e.d));
                chk("pulse_cycle", cyc, e.c);
            end
        end
    end

    task automatic win(input win_t v, input logic [15:0] e, input int gap, input int tail, input bit drop);
        for (int i = 0; i < 6; i++) begin
            sample_valid = 1'b1;
            sample_data  = v[i];
            @(posedge clk);
            #1;
            if (i == 0) chk("busy_first", 32'(window_busy), 32'd1);
            if (i == 5) exp_q.push_back('{d: e, c: cyc + 2});
            sample_valid = 1'b0;
            if (i < 5) repeat (gap) begin @(posedge clk); #1; end
        end
        if (drop) begin
            sample_valid = 1'b1;
            sample_data  = 16'h0005;
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
        end
        repeat (tail) begin @(posedge clk); #1; end
        if (tail >= 3) begin
            chk("busy_idle", 32'(window_busy), 32'd0);
            chk("data_held", 32'(filter_data), 32'(e));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 32'(filter_valid), 32'd0);
        chk("rst_data", 32'(filter_data), 32'd0);
        chk("rst_busy", 32'(window_busy), 32'd0);
        win('{16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000}, 16'd1000, 0, 3, 1'b0);
        win('{16'd100, 16'd100, 16'd60000, 16'd100, 16'd0, 16'd100}, 16'd100, 1, 3, 1'b0);
        win('{16'd2, 16'd2, 16'd3, 16'd3, 16'd0, 16'd9}, 16'd3, 0, 3, 1'b0);
        win('{16'd2, 16'd2, 16'd2, 16'd3, 16'd0, 16'd9}, 16'd2, 0, 3, 1'b0);
        win('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'hFFFF, 0, 3, 1'b0);
        win('{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 16'd0, 0, 3, 1'b0);
        win('{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60}, 16'd35, 0, 3, 1'b1);
        win('{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6}, 16'd4, 4, 4, 1'b0);
        win('{16'd400, 16'd300, 16'd200, 16'd100, 16'd500, 16'd600}, 16'd350, 4, 4, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_data  = 16'd7777;
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(window_busy), 32'd0);
        chk("midrst_data", 32'(filter_data), 32'd0);
        chk("midrst_valid", 32'(filter_valid), 32'd0);
        repeat (8) begin @(posedge clk); #1; end
        win('{16'd500, 16'd500, 16'd500, 16'd500, 16'd500, 16'd500}, 16'd500, 0, 3, 1'b0);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule

// File: doc/trim_avg_filter.md
Name: trim_avg_filter

Overview:
Conditions raw sensor samples before they reach the main measurement FSM. The block collects a window of 2^AVG_SHIFT+2 samples and discards one minimum and one maximum, which rejects single-sample spikes. It then outputs the rounded mean of the remaining 2^AVG_SHIFT samples. The result leaves as a one-cycle filter_valid pulse with a 16-bit filter_data word, which the main FSM latches while it waits for a new reading.

Parameters:
AVG_SHIFT, 2, log2 of the number of samples averaged after trimming; window length N = 2^AVG_SHIFT + 2; legal range 1..6

Ports:
clk  input  1  system clock (12 MHz)
rst  input  1  synchronous reset, active-high
sample_valid  input  1  one-cycle strobe: sample_data is valid this cycle
sample_data  input  16  unsigned raw sample
filter_valid  output  1  one-cycle strobe: filter_data holds a new result
filter_data  output  16  unsigned trimmed mean; held until the next result
window_busy  output  1  high while the current window has at least one sample or a result is being computed

Behaviour:
- Reset (rst high at a clk edge):
  - Outputs: filter_valid=0, filter_data=0, window_busy=0.
  - Internal state: state=S_ACC, sample count=0, sum=0, min=16'hFFFF, max=0.
  - Reset takes priority over every other event. Reset in the middle of a window discards the partial window; no result is emitted for it.
- Internal widths:
  - sum: 16+AVG_SHIFT+2 bits; it can never overflow.
  - cnt: counts 0..N-1.
- States:
  - S_ACC (collect):
    - On sample_valid: sum += sample_data; min = smaller of min and sample; max = larger of max and sample.
    - The first sample of a window initialises min and max to that sample.
    - On the N-th accepted sample, go to S_CALC and reset cnt to 0. Otherwise increment cnt.
  - S_CALC (one cycle):
    - trimmed = sum - min - max, then + 2^(AVG_SHIFT-1) for round-half-up.
    - Register trimmed >> AVG_SHIFT as the result.
    - Go to S_OUT.
  - S_OUT (one cycle):
    - filter_valid=1 and filter_data=result.
    - Clear sum, min and max; go to S_ACC.
- Latency: the N-th sample is accepted at edge t; filter_valid is high during the cycle after edge t+2.
- filter_valid is high for exactly one cycle per window. filter_data changes only on that cycle.
- Samples arriving while in S_CALC or S_OUT are dropped and not counted. The next window starts with the first sample_valid seen in S_ACC.
- Ties:
  - Only one instance of the min and one instance of the max are removed.
  - If every sample in the window is equal, two copies are removed and the result equals that value.
- Rounding: exact half-LSB results round up. The result can never exceed 16'hFFFF, because all-65535 input gives exactly 65535. No saturation logic is needed.
- window_busy:
  - Asserts on the edge that accepts the first sample of a window.
  - Stays high through S_CALC and S_OUT.
  - Deasserts on return to S_ACC with cnt=0.
- Free-running block: there is no enable. Downstream consumers ignore pulses they are not waiting for.

Test Plan:
- Reset, then 6 samples of 1000 at AVG_SHIFT=2 → a single filter_valid pulse 2 cycles after the 6th sample with filter_data=1000; filter_valid low on every other cycle.
- Spike rejection: 100,100,60000,100,0,100 → filter_data=100.
- Rounding: 2,2,3,3,0,9 → 3 (the exact 2.5 rounds up). Then 2,2,2,3,0,9 → 2 (2.25 rounds down).
- Full scale: six samples of 65535 → 65535, with no wrap. Six samples of 0 → 0.
- Drop window: present a sample_valid in the S_CALC cycle → that sample is not counted, and the next window still needs 6 fresh samples. Back-to-back windows with 5-cycle sample spacing → one pulse per window.
- Reset mid-window: assert rst after 3 samples → no pulse, window_busy=0, filter_data=0. The next 6 samples of 500 → filter_data=500.
